conv_filter_sched: RTL
======================

# conv_filter_sched

Sequencer for one convolution layer's filter loop. It steps the weight-ROM filter index and waits out the ROM-plus-weight-register latency. It then launches one feature-map pass per filter and advances on the pass's finish pulse, with downstream backpressure between filters. It sits between the layer control and the weight buffer / feature-map engine pair, and replaces free-running filter counting with an explicit start/busy/done handshake.

## Interface
- NUM_FILTERS, 8, maximum filters per layer; also the clamp for cfg_num_filters
- FW, 8, width of filter index and filter-count fields
- ROM_LAT, 2, cycles from filter_idx change to valid weights at the weight registers (ROM read 1 + register 1); legal values ≥1
- clk  in  1  single clock, all logic on rising edge
- Rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request to run a layer; sampled only in IDLE
- abort  in  1  cancel the current layer; highest priority after reset
- cfg_num_filters  in  FW  filters to run; sampled with start
- fmap_finish  in  1  one-cycle pulse from the feature-map engine: current pass complete
- out_ready  in  1  downstream can accept the next filter's output plane
- filter_idx  out  FW  weight-ROM address (filter number)
- wt_valid  out  1  weights for filter_idx are stable at the weight registers
- fmap_start  out  1  one-cycle pulse launching a feature-map pass
- busy  out  1  layer in progress (not IDLE)
- layer_done  out  1  one-cycle pulse when the last filter's pass finishes
- err_sticky  out  1  stray fmap_finish seen; cleared by an accepted start

## Operation
- States: IDLE, LOAD, RUN, WAIT_OUT, DONE. All outputs are registered.
- Reset and abort both force: IDLE, filter_idx=0, wt_valid=0, fmap_start=0, busy=0, layer_done=0. Reset also clears err_sticky; abort leaves err_sticky unchanged.
- IDLE: on start, latch n = min(cfg_num_filters, NUM_FILTERS), clear err_sticky, set filter_idx=0. If n==0, go to DONE. Otherwise go to LOAD with the latency counter at 0.
- LOAD: stays exactly ROM_LAT cycles with wt_valid=0, then goes to RUN.
- RUN: wt_valid=1 throughout. fmap_start=1 in the first RUN cycle only. On fmap_finish:
  - if filter_idx == n-1, go to DONE;
  - else if out_ready=1, go to LOAD with filter_idx+1;
  - else go to WAIT_OUT.
- WAIT_OUT: wt_valid=1. Hold filter_idx. When out_ready=1, go to LOAD with filter_idx+1.
- DONE: layer_done=1 for one cycle, busy=1, then IDLE. filter_idx returns to 0 on entering IDLE.
- fmap_finish outside RUN, or in the same cycle as fmap_start, is ignored for sequencing and sets err_sticky.
- start while busy is ignored; this includes the DONE cycle.
- abort and fmap_finish in the same cycle: abort wins, no layer_done.
- filter_idx never exceeds n-1, so there is no wrap-around.

## Timing
- start in cycle 0 → busy=1 and LOAD in cycles 1..ROM_LAT → fmap_start=1 in cycle ROM_LAT+1.
- Inter-filter gap: fmap_finish in cycle t with out_ready=1 → new filter_idx from cycle t+1 → fmap_start in cycle t+ROM_LAT+1.
- With backpressure: out_ready rising in cycle u (in WAIT_OUT) → fmap_start in cycle u+ROM_LAT+1.
- Last finish in cycle t → layer_done in cycle t+1 → busy=0 from cycle t+2. The next start is accepted from cycle t+2.
- n==0: start in cycle 0 → layer_done in cycle 1, no fmap_start.

## Structure
- Shared package conv_pkg holds the state enum (sched_state_t) and the default constants NUM_FILTERS and ROM_LAT, so the weight buffer and sequencer agree on them.
- No sub-module. The latency counter and FSM are kept in one module of about 150–200 lines.

## Test plan
- Nominal, ROM_LAT=2, cfg=8, out_ready=1, fmap_finish 10 cycles after each fmap_start → 8 fmap_starts with filter_idx 0..7, starts 13 cycles apart, one layer_done, err_sticky=0.
- Backpressure: out_ready=0 for 5 cycles after filter 2 finishes → state WAIT_OUT with filter_idx=2 held, wt_valid=1; fmap_start for filter 3 occurs ROM_LAT+1 cycles after out_ready rises.
- cfg=0 → layer_done in cycle 1, no fmap_start. cfg=20 → clamped to 8 passes.
- Abort during RUN on filter 4 → IDLE next cycle, filter_idx=0, busy=0, no layer_done. A following start begins at filter 0.
- Stray fmap_finish in IDLE and in LOAD → err_sticky=1, sequencing unchanged. A subsequent start clears err_sticky.
- Rst asserted mid-LOAD (asynchronous, between edges) → all outputs go to reset values immediately. start while busy and start in the DONE cycle are both ignored.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and scheduler state encoding for the convolution layer datapath.
// The weight buffer and the filter sequencer both import this package.
package conv_pkg;

  localparam int NUM_FILTERS = 8;
  localparam int FW          = 8;
  localparam int ROM_LAT     = 2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_RUN      = 3'd2,
    S_WAIT_OUT = 3'd3,
    S_DONE     = 3'd4
  } sched_state_t;

endpackage

// File: rtl/conv_filter_sched.sv
// Filter-loop sequencer: steps the weight-ROM index, waits out the ROM latency,
// launches one feature-map pass per filter and honours downstream backpressure.
module conv_filter_sched #(
  parameter int NUM_FILTERS = conv_pkg::NUM_FILTERS,
  parameter int FW          = conv_pkg::FW,
  parameter int ROM_LAT     = conv_pkg::ROM_LAT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [FW-1:0] cfg_num_filters,
  input  logic          fmap_finish,
  input  logic          out_ready,
  output logic [FW-1:0] filter_idx,
  output logic          wt_valid,
  output logic          fmap_start,
  output logic          busy,
  output logic          layer_done,
  output logic          err_sticky
);
  import conv_pkg::*;

  localparam int            LW       = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(ROM_LAT - 1);
  localparam logic [FW-1:0] MAX_N    = FW'(NUM_FILTERS);

  sched_state_t  state;
  logic [FW-1:0] num_filt;
  logic [LW-1:0] lat_cnt;
  logic [FW-1:0] n_clamped;
  logic          stray;
  logic          last_filt;

  // A finish in the launch cycle cannot belong to the pass just started.
  always_comb begin
    n_clamped = (cfg_num_filters > MAX_N) ? MAX_N : cfg_num_filters;
    stray     = fmap_finish && ((state != S_RUN) || fmap_start);
    last_filt = (filter_idx == (num_filt - FW'(1)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      filter_idx <= '0;
      num_filt   <= '0;
      lat_cnt    <= '0;
      wt_valid   <= 1'b0;
      fmap_start <= 1'b0;
      busy       <= 1'b0;
      layer_done <= 1'b0;
      err_sticky <= 1'b0;
    end else if (abort) begin
      state      <= S_IDLE;
      filter_idx <= '0;
      lat_cnt    <= '0;
      wt_valid   <= 1'b0;
      fmap_start <= 1'b0;
      busy       <= 1'b0;
      layer_done <= 1'b0;
    end else begin
      fmap_start <= 1'b0;
      layer_done <= 1'b0;
      if (stray) err_sticky <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start) begin
            num_filt   <= n_clamped;
            filter_idx <= '0;
            lat_cnt    <= '0;
            busy       <= 1'b1;
            err_sticky <= stray;
            if (n_clamped == '0) begin
              state      <= S_DONE;
              layer_done <= 1'b1;
            end else begin
              state <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          if (lat_cnt == LAT_LAST) begin
            state      <= S_RUN;
            wt_valid   <= 1'b1;
            fmap_start <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end

        S_RUN: begin
          if (fmap_finish && !fmap_start) begin
            if (last_filt) begin
              state      <= S_DONE;
              wt_valid   <= 1'b0;
              layer_done <= 1'b1;
            end else if (out_ready) begin
              state      <= S_LOAD;
              filter_idx <= filter_idx + FW'(1);
              wt_valid   <= 1'b0;
              lat_cnt    <= '0;
            end else begin
              state <= S_WAIT_OUT;
            end
          end
        end

        S_WAIT_OUT: begin
          if (out_ready) begin
            state      <= S_LOAD;
            filter_idx <= filter_idx + FW'(1);
            wt_valid   <= 1'b0;
            lat_cnt    <= '0;
          end
        end

        S_DONE: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          filter_idx <= '0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
